// File: rtl/bcd_converter_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), one input bit per clock, start/busy/done handshake.
// Optional build macro BCD_SATURATE_EN: overflowed results read as all-9 digits.
module bcd_converter_seq #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [BIN_WIDTH-1:0] bin_sr, bin_nxt;
    logic [BCD_W-1:0]     work, work_nxt, adj;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 ovf_flag, ovf_nxt;
    logic [BCD_W-1:0]     bcd_nxt;
    logic                 overflow_nxt, busy_nxt, done_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bin_sr   <= '0;
            work     <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bin_sr   <= bin_nxt;
            work     <= work_nxt;
            count    <= count_nxt;
            ovf_flag <= ovf_nxt;
            bcd_out  <= bcd_nxt;
            overflow <= overflow_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_nxt    = state;
        bin_nxt      = bin_sr;
        work_nxt     = work;
        count_nxt    = count;
        ovf_nxt      = ovf_flag;
        bcd_nxt      = bcd_out;
        overflow_nxt = overflow;

        // Add-3 correction so each digit carries correctly on the following doubling
        adj = work;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    bin_nxt   = bin_in;
                    work_nxt  = '0;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            ST_SHIFT: begin
                work_nxt = {adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
                bin_nxt  = {bin_sr[BIN_WIDTH-2:0], 1'b0};
                // A bit leaving the top digit means the value needs more digits
                ovf_nxt  = ovf_flag | adj[BCD_W-1];
                if (count == CNT_W'(BIN_WIDTH - 1)) begin
                    state_nxt    = ST_DONE;
                    overflow_nxt = ovf_nxt;
                    bcd_nxt      = work_nxt;
`ifdef BCD_SATURATE_EN
                    if (ovf_nxt) begin
                        bcd_nxt = {DIGITS{4'h9}};
                    end
`endif
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
    end
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: a 5-digit and a 4-digit instance share clock and stimulus.
module tb_bcd_converter_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
    );

    bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, low digit first, truncated to the given digit count
    function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned digits);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int unsigned k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp4(input int unsigned v);
`ifdef BCD_SATURATE_EN
        if (v >= 10000) return 32'h9999;
`endif
        return to_bcd(v, 4);
    endfunction

    // One conversion; latency counted in cycles after the accepting edge
    task automatic conv(input logic [15:0] v, input bit detail);
        int n;
        bit busy_ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (!done5 && n < 40) begin
            if (!busy5) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (detail) begin
            check("latency", 32'(n), 32'd16);
            check("busy_during", {31'd0, busy_ok & busy5}, 32'd1);
        end else if (n >= 40) begin
            check("timeout", 32'(n), 32'd16);
        end
        check($sformatf("bcd5[%0d]", v), {12'd0, bcd5}, to_bcd(32'(v), 5));
        check($sformatf("ovf5[%0d]", v), {31'd0, ovf5}, 32'd0);
        check($sformatf("bcd4[%0d]", v), {16'd0, bcd4}, exp4(32'(v)));
        check($sformatf("ovf4[%0d]", v), {31'd0, ovf4}, {31'd0, (v >= 16'd10000)});
        if (detail) begin
            @(negedge clk);
            check("done_width", {31'd0, done5}, 32'd0);
            check("busy_after", {31'd0, busy5}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int dones;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy5}, 32'd0);
        check("rst_done", {31'd0, done5}, 32'd0);
        check("rst_bcd",  {12'd0, bcd5}, 32'd0);
        check("rst_ovf",  {31'd0, ovf5}, 32'd0);

        // reset and start together: reset wins
        start  = 1'b1;
        bin_in = 16'd99;
        @(negedge clk);
        start  = 1'b0;
        reset  = 1'b0;
        check("rst_start_busy", {31'd0, busy5}, 32'd0);

        conv(16'd0, 1'b1);
        conv(16'd1234, 1'b1);
        conv(16'd65535, 1'b1);
        conv(16'd9999, 1'b1);
        conv(16'd10000, 1'b1);
        conv(16'd59999, 1'b1);

        // start while busy is ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd42;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd7;
        @(negedge clk);
        start  = 1'b0;
        dones  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done5) dones++;
            @(negedge clk);
        end
        check("busy_start_dones", 32'(dones), 32'd1);
        check("busy_start_bcd", {12'd0, bcd5}, 32'h00042);

        // reset mid-conversion aborts without a done pulse
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clk);
        start  = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_bcd",  {12'd0, bcd5}, 32'd0);
        check("abort_busy", {31'd0, busy5}, 32'd0);
        check("abort_ovf4", {31'd0, ovf4}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done5) n++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(n), 32'd0);
        conv(16'd4321, 1'b1);

        // Back-to-back sweep of low values plus a strided pass over the full range
        for (int v = 0; v < 1200; v++) conv(16'(v), 1'b0);
        for (int v = 1200; v < 65536; v += 1009) conv(16'(v), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
